// File: rtl/braille_pkg.sv
// braille_pkg: shared constants, FSM encoding and letter-to-dot table for the Braille cell driver
package braille_pkg;
   localparam int DOT_W = 6;
   localparam int NUM_CLASSES_DEF = 26;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [DOT_W-1:0] DOT_LUT [0:25] = '{
      6'h01, 6'h03, 6'h09, 6'h19, 6'h11, 6'h0B, 6'h1B, 6'h13, 6'h0A, 6'h1A,
      6'h05, 6'h07, 6'h0D, 6'h1D, 6'h15, 6'h0F, 6'h1F, 6'h17, 6'h0E, 6'h1E,
      6'h25, 6'h27, 6'h3A, 6'h2D, 6'h3D, 6'h35
   };
endpackage

// File: rtl/braille_lut.sv
// braille_lut: combinational class index to 6-dot pattern, blank and flagged when out of range
module braille_lut
   import braille_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
   input  logic [7:0]       alpha,
   output logic [DOT_W-1:0] dots,
   output logic             bad
);
   // out-of-range classes read back as a blank cell
   always_comb begin
      bad  = alpha >= 8'(NUM_CLASSES);
      dots = bad ? '0 : DOT_LUT[alpha[4:0]];
   end
endmodule

// File: rtl/braille_cell_driver.sv
// braille_cell_driver: buffers classifier letters and shows each as a timed Braille cell followed by a blank gap
module braille_cell_driver
   import braille_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 100000000,
   parameter int GAP_CYCLES  = 10000000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_valid,
   input  logic [7:0]                    i_alpha,
   input  logic                          i_clr_ovf,
   output logic [DOT_W-1:0]              o_dots,
   output logic                          o_cell_active,
   output logic                          o_char_done,
   output logic                          o_bad_class,
   output logic                          o_overflow,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int HG = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW = $clog2(HG > 2 ? HG : 2);
   localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [1:0]       state;
   logic [TW-1:0]    timer;
   logic [DOT_W-1:0] lut_dots;
   logic             lut_bad, pop, full, push;

   braille_lut #(.NUM_CLASSES(NUM_CLASSES)) u_lut (
      .alpha (mem[rd_ptr]),
      .dots  (lut_dots),
      .bad   (lut_bad)
   );

   // a pop frees a slot on the same edge, so a full FIFO still accepts a push while the FSM is taking a letter
   always_comb begin
      pop           = state == S_IDLE && o_fifo_level != '0;
      full          = o_fifo_level == LW'(FIFO_DEPTH);
      push          = i_valid && (!full || pop);
      o_cell_active = state == S_HOLD;
      o_char_done   = timer == '0 && (state == S_GAP || (state == S_HOLD && GAP_CYCLES == 0));
      o_busy        = state != S_IDLE || o_fifo_level != '0;
   end

   // storage needs no reset; emptiness is defined by the pointers and level
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= i_alpha;

   // FIFO pointers, occupancy and sticky overflow where a new drop beats a clear
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         o_fifo_level <= '0;
         o_overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         o_fifo_level <= o_fifo_level + LW'(push) - LW'(pop);
         o_overflow   <= (i_valid && !push) ? 1'b1 : (i_clr_ovf ? 1'b0 : o_overflow);
      end

   // cell sequencer: IDLE pops a letter, HOLD drives its dots, GAP keeps the actuators blank
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= S_IDLE;
         timer       <= '0;
         o_dots      <= '0;
         o_bad_class <= 1'b0;
      end else begin
         o_bad_class <= 1'b0;
         if (state == S_IDLE) begin
            if (pop) begin
               o_dots      <= lut_dots;
               o_bad_class <= lut_bad;
               timer       <= HOLD_LD;
               state       <= S_HOLD;
            end
         end else if (timer != '0) begin
            timer <= timer - TW'(1);
         end else if (state == S_HOLD && GAP_CYCLES > 0) begin
            o_dots <= '0;
            timer  <= GAP_LD;
            state  <= S_GAP;
         end else begin
            o_dots <= '0;
            state  <= S_IDLE;
         end
      end
endmodule

// File: tb/tb_braille_cell_driver.sv
// tb_braille_cell_driver: directed checks of timing, patterns, FIFO overflow and reset of the Braille cell driver
module tb_braille_cell_driver;
   logic       clk, reset, i_valid, i_clr_ovf;
   logic [7:0] i_alpha;
   logic [5:0] o_dots;
   logic       o_cell_active, o_char_done, o_bad_class, o_overflow, o_busy;
   logic [2:0] o_fifo_level;
   int checks = 0;
   int errors = 0;
   logic [5:0] tbl [26];

   braille_cell_driver #(
      .NUM_CLASSES (26),
      .FIFO_DEPTH  (4),
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_valid       (i_valid),
      .i_alpha       (i_alpha),
      .i_clr_ovf     (i_clr_ovf),
      .o_dots        (o_dots),
      .o_cell_active (o_cell_active),
      .o_char_done   (o_char_done),
      .o_bad_class   (o_bad_class),
      .o_overflow    (o_overflow),
      .o_busy        (o_busy),
      .o_fifo_level  (o_fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({o_dots, o_cell_active, o_char_done, o_bad_class, o_overflow, o_busy, o_fifo_level} !== 14'b0) begin
         errors++;
         $display("FAIL reset_outputs got dots=%b act=%b done=%b bad=%b ovf=%b busy=%b lvl=%0d exp all 0",
                  o_dots, o_cell_active, o_char_done, o_bad_class, o_overflow, o_busy, o_fifo_level);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single;
      i_valid = 1'b1; i_alpha = 8'd0;
      step();
      i_valid = 1'b0;
      checks++;
      if (o_fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", o_fifo_level); end
      for (int c = 1; c <= 7; c++) begin
         step();
         checks++;
         if (o_dots !== (c <= 4 ? 6'b000001 : 6'b0) || o_cell_active !== (c <= 4) ||
             o_char_done !== (c == 6) || o_busy !== (c <= 6)) begin
            errors++;
            $display("FAIL single_c%0d got dots=%b act=%b done=%b busy=%b exp dots=%b act=%b done=%b busy=%b",
                     c, o_dots, o_cell_active, o_char_done, o_busy,
                     c <= 4 ? 6'b000001 : 6'b0, c <= 4, c == 6, c <= 6);
         end
      end
   endtask

   task automatic test_patterns;
      for (int i = 0; i < 26; i++) begin
         i_valid = 1'b1; i_alpha = 8'(i);
         step();
         i_valid = 1'b0;
         step();
         checks++;
         if (o_dots !== tbl[i] || o_bad_class !== 1'b0) begin
            errors++;
            $display("FAIL pattern_%0d got dots=%b bad=%b exp dots=%b bad=0", i, o_dots, o_bad_class, tbl[i]);
         end
         repeat (6) step();
         checks++;
         if (o_busy !== 1'b0) begin errors++; $display("FAIL pattern_%0d_idle got busy=%b exp 0", i, o_busy); end
      end
   endtask

   task automatic test_burst;
      int lv [5];
      int starts;
      logic prev_act;
      logic [5:0] exp;
      lv = '{1, 1, 2, 3, 4};
      starts = 0;
      prev_act = 1'b0;
      for (int c = 0; c <= 40; c++) begin
         i_valid = c <= 5; i_alpha = 8'(c);
         step();
         if (c <= 4) begin
            checks++;
            if (o_fifo_level !== 3'(lv[c]) || o_overflow !== 1'b0) begin
               errors++;
               $display("FAIL burst_level_c%0d got lvl=%0d ovf=%b exp lvl=%0d ovf=0", c, o_fifo_level, o_overflow, lv[c]);
            end
         end
         if (c == 5) begin
            checks++;
            if (o_fifo_level !== 3'd4 || o_overflow !== 1'b1) begin
               errors++;
               $display("FAIL burst_drop got lvl=%0d ovf=%b exp lvl=4 ovf=1", o_fifo_level, o_overflow);
            end
         end
         exp = (c >= 1 && (c - 1) / 7 < 5 && (c - 1) % 7 < 4) ? tbl[(c - 1) / 7] : 6'b0;
         checks++;
         if (o_dots !== exp) begin errors++; $display("FAIL burst_dots_c%0d got %b exp %b", c, o_dots, exp); end
         if (o_cell_active && !prev_act) starts++;
         prev_act = o_cell_active;
      end
      i_valid = 1'b0;
      checks++;
      if (starts !== 5 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_cells got cells=%0d busy=%b exp cells=5 busy=0", starts, o_busy);
      end
      i_clr_ovf = 1'b1;
      step();
      i_clr_ovf = 1'b0;
      checks++;
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL burst_clr_ovf got %b exp 0", o_overflow); end
   endtask

   task automatic test_bad_class;
      i_valid = 1'b1; i_alpha = 8'd30;
      step();
      i_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         step();
         checks++;
         if (o_dots !== 6'b0 || o_bad_class !== (c == 1) || o_cell_active !== (c <= 4) ||
             o_char_done !== (c == 6) || o_busy !== (c <= 6)) begin
            errors++;
            $display("FAIL bad_class_c%0d got dots=%b bad=%b act=%b done=%b busy=%b exp dots=0 bad=%b act=%b done=%b busy=%b",
                     c, o_dots, o_bad_class, o_cell_active, o_char_done, o_busy, c == 1, c <= 4, c == 6, c <= 6);
         end
      end
   endtask

   task automatic test_reset_mid_hold;
      for (int c = 0; c <= 2; c++) begin
         i_valid = 1'b1; i_alpha = 8'(c);
         step();
      end
      i_valid = 1'b0;
      checks++;
      if (o_dots !== 6'b000001 || o_fifo_level !== 3'd2) begin
         errors++;
         $display("FAIL rst_pre got dots=%b lvl=%0d exp dots=000001 lvl=2", o_dots, o_fifo_level);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (o_dots !== 6'b0 || o_fifo_level !== 3'd0 || o_cell_active !== 1'b0 || o_busy !== 1'b0 || o_char_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_async got dots=%b lvl=%0d act=%b busy=%b done=%b exp all 0",
                  o_dots, o_fifo_level, o_cell_active, o_busy, o_char_done);
      end
      step();
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (o_dots !== 6'b0 || o_fifo_level !== 3'd0 || o_busy !== 1'b0 || o_char_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_c%0d got dots=%b lvl=%0d busy=%b done=%b exp all 0",
                     c, o_dots, o_fifo_level, o_busy, o_char_done);
         end
      end
   endtask

   task automatic test_full_push_pop;
      int n;
      for (int c = 0; c <= 8; c++) begin
         i_valid = c <= 4 || c == 8; i_alpha = 8'(c);
         step();
         if (c == 7) begin
            checks++;
            if (o_fifo_level !== 3'd4 || o_busy !== 1'b1 || o_cell_active !== 1'b0) begin
               errors++;
               $display("FAIL pushpop_pre got lvl=%0d busy=%b act=%b exp lvl=4 busy=1 act=0", o_fifo_level, o_busy, o_cell_active);
            end
         end
      end
      i_valid = 1'b0;
      checks++;
      if (o_fifo_level !== 3'd4 || o_overflow !== 1'b0 || o_dots !== tbl[1]) begin
         errors++;
         $display("FAIL pushpop got lvl=%0d ovf=%b dots=%b exp lvl=4 ovf=0 dots=%b", o_fifo_level, o_overflow, o_dots, tbl[1]);
      end
      n = 0;
      while (o_busy && n < 200) begin step(); n++; end
      checks++;
      if (o_busy !== 1'b0 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_drain got busy=%b ovf=%b after %0d cycles exp busy=0 ovf=0", o_busy, o_overflow, n);
      end
   endtask

   initial begin
      tbl = '{6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001, 6'b001011, 6'b011011,
              6'b010011, 6'b001010, 6'b011010, 6'b000101, 6'b000111, 6'b001101, 6'b011101,
              6'b010101, 6'b001111, 6'b011111, 6'b010111, 6'b001110, 6'b011110, 6'b100101,
              6'b100111, 6'b111010, 6'b101101, 6'b111101, 6'b110101};
      i_valid = 1'b0; i_alpha = 8'd0; i_clr_ovf = 1'b0;
      test_reset();
      test_single();
      test_patterns();
      test_burst();
      test_bad_class();
      test_reset_mid_hold();
      test_full_push_pop();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
